// File: rtl/instr_fetch_unit.sv
// Instruction memory with its own program counter and fetch sequencer.
// Loader writes while idle/halted; decode consumes words over a valid/ready
// handshake. One fetch is in flight at a time, so throughput is one word per
// two cycles. HALT_OPCODE stops fetching until run is dropped.
module instr_fetch_unit #(
    parameter int                      INSTR_WIDTH  = 16,
    parameter int                      ADDR_WIDTH   = 5,
    parameter int                      OPCODE_WIDTH = 4,
    parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE  = 4'b1111
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_instr,
    input  logic [ADDR_WIDTH-1:0]  load_instr_address,
    input  logic [INSTR_WIDTH-1:0] instruction_input,
    input  logic                   run,
    input  logic                   jump_valid,
    input  logic [ADDR_WIDTH-1:0]  jump_address,
    input  logic                   instr_ready,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic                   halted
);
    localparam int DEPTH = 2**ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_VALID, S_HALTED} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [INSTR_WIDTH-1:0]  r_mem [DEPTH];
    logic [INSTR_WIDTH-1:0]  r_rd_data;
    logic [INSTR_WIDTH-1:0]  r_instr;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic [ADDR_WIDTH-1:0]   w_pc_nxt;
    logic                    r_valid;
    logic                    r_halted;
    logic                    w_hs;
    logic                    w_is_halt;
    logic                    w_wr_en;

    // r_valid is only ever set in VALID, so this is the accepting handshake
    assign w_hs      = r_valid & instr_ready;
    assign w_is_halt = (r_instr[INSTR_WIDTH-1 -: OPCODE_WIDTH] == HALT_OPCODE);
    // Loader may only touch memory while no fetch is in flight
    assign w_wr_en   = load_instr & ((r_state == S_IDLE) | (r_state == S_HALTED));

    // Next-state and next-pc; w_pc_nxt doubles as the memory read address
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        case (r_state)
            S_IDLE: begin
                if (run) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                w_state_nxt = S_VALID;
            end
            S_VALID: begin
                if (w_hs) begin
                    if (w_is_halt) begin
                        w_state_nxt = S_HALTED;
                    end else begin
                        w_pc_nxt    = jump_valid ? jump_address : r_pc + ADDR_WIDTH'(1);
                        w_state_nxt = run ? S_FETCH : S_IDLE;
                    end
                end
            end
            S_HALTED: begin
                if (!run) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register; reset abandons any in-flight fetch
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Memory write port and synchronous read port (contents survive reset)
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[load_instr_address] <= instruction_input;
        r_rd_data <= r_mem[w_pc_nxt];
    end

    // Registered outputs: pc, valid, halted flag and captured instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= '0;
            r_valid  <= 1'b0;
            r_instr  <= '0;
            r_halted <= 1'b0;
        end else begin
            r_pc     <= w_pc_nxt;
            r_valid  <= (w_state_nxt == S_VALID);
            r_halted <= (w_state_nxt == S_HALTED);
            if (r_state == S_FETCH) r_instr <= r_rd_data;
        end
    end

    assign instr_valid = r_valid;
    assign instruction = r_instr;
    assign pc          = r_pc;
    assign halted      = r_halted;
endmodule
